// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode 7-segment scan controller with blanking and
// frame-synchronous double buffering. Optional macro: SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] digits_i,
  input  logic [7:0]  digit_en_i,
  input  logic        load_i,
  output logic [6:0]  seg_o,
  output logic [7:0]  an_o,
  output logic        upd_pending_o,
  output logic        frame_done_o
);

  localparam int unsigned MAXT       = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int unsigned CW         = $clog2(MAXT + 1);
  localparam int unsigned SHOW_LAST  = TICKS_PER_DIGIT - 1;
  localparam int unsigned BLANK_LAST = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic            boundary;

  logic [31:0]     pend_data_q, pend_data_d;
  logic [7:0]      pend_en_q, pend_en_d;
  logic            upd_q, upd_d;
  logic [31:0]     shd_data_q, shd_data_d;
  logic [7:0]      shd_mask_q, shd_mask_d;
  logic [7:0]      eff_mask;

  logic            lit;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      an_q, an_d;
  logic            fd_q, fd_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // Clear enabled zero digits from the top down until the first enabled nonzero; digit 0 always stays.
  function automatic logic [7:0] lz_mask(input logic [31:0] d, input logic [7:0] en);
    logic [7:0] m;
    logic       seen;
    m    = en;
    seen = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      if (en[k] && !seen) begin
        if (d[4*k +: 4] == 4'h0) m[k] = 1'b0;
        else                     seen = 1'b1;
      end
    end
    return m;
  endfunction

  assign eff_mask = lz_mask(pend_data_q, pend_en_q);
`else
  assign eff_mask = pend_en_q;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tick_d   = tick_q + CW'(1);
    boundary = 1'b0;
    if (state_q == ST_BLANK) begin
      if (tick_q == CW'(BLANK_LAST)) begin
        state_d = ST_SHOW;
        tick_d  = '0;
      end
    end else if (tick_q == CW'(SHOW_LAST)) begin
      idx_d    = idx_q + 3'd1;
      tick_d   = '0;
      state_d  = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
      boundary = (idx_q == 3'd7);
    end
  end

  // A load coinciding with the boundary lands in pending after the old pending moves to shadow.
  always_comb begin
    shd_data_d  = shd_data_q;
    shd_mask_d  = shd_mask_q;
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    upd_d       = upd_q;
    if (boundary && upd_q) begin
      shd_data_d = pend_data_q;
      shd_mask_d = eff_mask;
      upd_d      = 1'b0;
    end
    if (load_i) begin
      pend_data_d = digits_i;
      pend_en_d   = digit_en_i;
      upd_d       = 1'b1;
    end
  end

  // Outputs are computed from next state so they change on the first edge of each phase.
  always_comb begin
    lit   = (state_d == ST_SHOW) && shd_mask_d[idx_d];
    an_d  = lit ? ~(8'h01 << idx_d) : 8'hFF;
    seg_d = lit ? hex7(shd_data_d[{idx_d, 2'b00} +: 4]) : 7'h7F;
    fd_d  = (state_d == ST_SHOW) && (idx_d == 3'd7) && (tick_d == CW'(SHOW_LAST));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
      idx_q       <= '0;
      tick_q      <= '0;
      pend_data_q <= '0;
      pend_en_q   <= '0;
      upd_q       <= 1'b0;
      shd_data_q  <= '0;
      shd_mask_q  <= '0;
      seg_q       <= 7'h7F;
      an_q        <= 8'hFF;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      pend_data_q <= pend_data_d;
      pend_en_q   <= pend_en_d;
      upd_q       <= upd_d;
      shd_data_q  <= shd_data_d;
      shd_mask_q  <= shd_mask_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign upd_pending_o = upd_q;
  assign frame_done_o  = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with TICKS_PER_DIGIT=4, BLANK_TICKS=1 (5-cycle slots, 40-cycle frames).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] digits_i;
  logic [7:0]  digit_en_i;
  logic        load_i;
  logic [6:0]  seg_o;
  logic [7:0]  an_o;
  logic        upd_pending_o;
  logic        frame_done_o;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.TICKS_PER_DIGIT(4), .BLANK_TICKS(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .digits_i(digits_i), .digit_en_i(digit_en_i),
    .load_i(load_i), .seg_o(seg_o), .an_o(an_o), .upd_pending_o(upd_pending_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done_o !== 1'b1 && n < 200);
    chk(tag, {31'd0, frame_done_o}, 32'd1);
  endtask

  // Called on the negedge right after a reset edge; releases reset and checks a dark 40-cycle frame.
  task automatic rst_frame(input string tag);
    int   n;
    logic lit;
    chk({tag, "_rst_an"},  {24'd0, an_o}, 32'hFF);
    chk({tag, "_rst_seg"}, {25'd0, seg_o}, 32'h7F);
    chk({tag, "_rst_upd"}, {31'd0, upd_pending_o}, 32'd0);
    chk({tag, "_rst_fd"},  {31'd0, frame_done_o}, 32'd0);
    reset_i = 1'b0;
    n   = 1;
    lit = 1'b0;
    while (frame_done_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (an_o !== 8'hFF || seg_o !== 7'h7F) lit = 1'b1;
    end
    chk({tag, "_fd_cycle"}, n, 32'd40);
    chk({tag, "_dark"}, {31'd0, lit}, 32'd0);
    chk({tag, "_upd"}, {31'd0, upd_pending_o}, 32'd0);
  endtask

  // Starts on a frame_done negedge and ends on the next one; checks every cycle of the frame.
  task automatic check_frame(input string tag, input logic [7:0] en, input logic [55:0] segs,
                             input logic exp_upd);
    logic [7:0] one;
    logic [7:0] ea;
    logic [6:0] es;
    one = 8'h01;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      load_i = 1'b0;
      if (k == 0) chk({tag, "_upd"}, {31'd0, upd_pending_o}, {31'd0, exp_upd});
      chk($sformatf("%s_s%0d_blank_an", tag, k), {24'd0, an_o}, 32'hFF);
      ea = en[k] ? ~(one << k) : 8'hFF;
      es = en[k] ? segs[7*k +: 7] : 7'h7F;
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        chk($sformatf("%s_s%0d_an", tag, k), {24'd0, an_o}, {24'd0, ea});
        chk($sformatf("%s_s%0d_seg", tag, k), {25'd0, seg_o}, {25'd0, es});
      end
    end
    chk({tag, "_fd"}, {31'd0, frame_done_o}, 32'd1);
  endtask

  task automatic load_mid(input string tag, input logic [31:0] d, input logic [7:0] e);
    repeat (3) @(negedge clk);
    digits_i   = d;
    digit_en_i = e;
    load_i     = 1'b1;
    @(negedge clk);
    load_i     = 1'b0;
    digits_i   = $urandom;
    digit_en_i = 8'($urandom);
    chk({tag, "_upd_set"}, {31'd0, upd_pending_o}, 32'd1);
  endtask

  initial begin
    reset_i    = 1'b1;
    digits_i   = '0;
    digit_en_i = '0;
    load_i     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_frame("t1");

    load_mid("t2", 32'hFEDCBA98, 8'hFF);
    wait_fd("t2_wait");
    chk("t2_upd_at_fd", {31'd0, upd_pending_o}, 32'd1);
    check_frame("t2", 8'hFF, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 1'b0);

    load_mid("t3", 32'h76543210, 8'h05);
    wait_fd("t3_wait");
    check_frame("t3", 8'h05, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h7F, 7'h40}, 1'b0);

    load_mid("t4a", 32'h11111111, 8'hFF);
    load_mid("t4b", 32'h22222222, 8'hFF);
    wait_fd("t4_wait");
    check_frame("t4_f1", 8'hFF, {8{7'h24}}, 1'b0);
    digits_i   = 32'h33333333;
    digit_en_i = 8'hFF;
    load_i     = 1'b1;
    check_frame("t4_f2", 8'hFF, {8{7'h24}}, 1'b1);
    check_frame("t4_f3", 8'hFF, {8{7'h30}}, 1'b0);

    repeat (2) @(negedge clk);
    digits_i   = 32'h55555555;
    digit_en_i = 8'hFF;
    load_i     = 1'b1;
    @(negedge clk);
    load_i     = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_pre_an", {24'd0, an_o}, 32'hEF);
    chk("t5_pre_seg", {25'd0, seg_o}, 32'h30);
    reset_i = 1'b1;
    @(negedge clk);
    rst_frame("t5");
    check_frame("t5_after", 8'h00, {8{7'h7F}}, 1'b0);

`ifdef SEG7_LZ_BLANK_EN
    load_mid("t6a", 32'h00000300, 8'hFF);
    wait_fd("t6a_wait");
    check_frame("t6a", 8'h07, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40}, 1'b0);
    load_mid("t6b", 32'h00000000, 8'hFF);
    wait_fd("t6b_wait");
    check_frame("t6b", 8'h01, {8{7'h40}}, 1'b0);
`else
    load_mid("t6a", 32'h00000300, 8'hFF);
    wait_fd("t6a_wait");
    check_frame("t6a", 8'hFF, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40}, 1'b0);
    load_mid("t6b", 32'h00000000, 8'hFF);
    wait_fd("t6b_wait");
    check_frame("t6b", 8'hFF, {8{7'h40}}, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
